// File: rtl/fetch_stage_ctrl.sv
// Instruction-fetch stage controller: owns the PC, the single-outstanding request
// to instruction memory, a one-entry skid buffer and the IF/ID register.
module fetch_stage_ctrl #(
    parameter int unsigned          ADDR_W    = 16,
    parameter int unsigned          INSTR_W   = 16,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pc_write_en,
    input  logic                if_id_write_en,
    input  logic                if_id_clean,
    input  logic                doJump,
    input  logic [ADDR_W-1:0]   jump_target,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [ADDR_W-1:0]   if_id_pc1,
    output logic                if_id_valid,
    output logic [15:0]         bubble_count
);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [ADDR_W-1:0]    fetch_addr_q, fetch_addr_d;
    logic                 kill_q, kill_d;
    logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0]    skid_pc1_q, skid_pc1_d;
    logic [INSTR_W-1:0]   ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0]    ifid_pc1_q, ifid_pc1_d;
    logic                 ifid_valid_q, ifid_valid_d;
    logic [15:0]          bubble_cnt_q, bubble_cnt_d;

    logic                 advance;
    logic                 new_avail;
    logic [INSTR_W-1:0]   new_instr;
    logic [ADDR_W-1:0]    new_pc1;

    // A pc_write_en / if_id_write_en mismatch is treated as a stall.
    assign advance = pc_write_en & if_id_write_en;

    // NOTE: every variable written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        kill_d       = kill_q;
        skid_instr_d = skid_instr_q;
        skid_pc1_d   = skid_pc1_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc1_d   = ifid_pc1_q;
        ifid_valid_d = ifid_valid_q;
        bubble_cnt_d = bubble_cnt_q;
        new_avail    = 1'b0;
        new_instr    = imem_rdata;
        new_pc1      = fetch_addr_q + ADDR_ONE;

        // Jump beats stall; later branches only override when no jump is present.
        if (doJump) begin
            pc_d = jump_target;
        end

        unique case (state_q)
            ST_ISSUE: begin
                state_d      = ST_WAIT;
                fetch_addr_d = doJump ? jump_target : pc_q;
            end
            ST_WAIT: begin
                if (imem_ack) begin
                    if (kill_q || doJump) begin
                        kill_d  = 1'b0;
                        state_d = ST_ISSUE;
                    end else if (advance) begin
                        new_avail    = 1'b1;
                        pc_d         = pc_q + ADDR_ONE;
                        fetch_addr_d = pc_q + ADDR_ONE;
                    end else begin
                        skid_instr_d = imem_rdata;
                        skid_pc1_d   = fetch_addr_q + ADDR_ONE;
                        state_d      = ST_HOLD;
                    end
                end else if (doJump) begin
                    // The old request stays up until its ack, which is then dropped.
                    kill_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (doJump) begin
                    state_d = ST_ISSUE;
                end else if (advance) begin
                    new_avail = 1'b1;
                    new_instr = skid_instr_q;
                    new_pc1   = skid_pc1_q;
                    pc_d      = pc_q + ADDR_ONE;
                    state_d   = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_ISSUE;
            end
        endcase

        if (if_id_clean) begin
            ifid_instr_d = NOP_INSTR;
            ifid_pc1_d   = '0;
            ifid_valid_d = 1'b0;
        end else if (if_id_write_en) begin
            if (new_avail) begin
                ifid_instr_d = new_instr;
                ifid_pc1_d   = new_pc1;
                ifid_valid_d = 1'b1;
            end else begin
                ifid_instr_d = NOP_INSTR;
                ifid_pc1_d   = '0;
                ifid_valid_d = 1'b0;
                if (bubble_cnt_q != 16'hFFFF) begin
                    bubble_cnt_d = bubble_cnt_q + 16'd1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_ISSUE;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            kill_q       <= 1'b0;
            skid_instr_q <= '0;
            skid_pc1_q   <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc1_q   <= '0;
            ifid_valid_q <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            kill_q       <= kill_d;
            skid_instr_q <= skid_instr_d;
            skid_pc1_q   <= skid_pc1_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc1_q   <= ifid_pc1_d;
            ifid_valid_q <= ifid_valid_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Request and address come straight from registers: no path from hazard inputs.
    assign imem_req     = (state_q == ST_WAIT);
    assign imem_addr    = fetch_addr_q;
    assign if_id_instr  = ifid_instr_q;
    assign if_id_pc1    = ifid_pc1_q;
    assign if_id_valid  = ifid_valid_q;
    assign bubble_count = bubble_cnt_q;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Self-checking bench for fetch_stage_ctrl: directed scenarios followed by random
// stimulus, all compared against a transaction-level model of the fetch stage.
module tb_fetch_stage_ctrl;

    logic        clk;
    logic        rst;
    logic        pc_write_en;
    logic        if_id_write_en;
    logic        if_id_clean;
    logic        doJump;
    logic [15:0] jump_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc1;
    logic        if_id_valid;
    logic [15:0] bubble_count;

    fetch_stage_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .pc_write_en    (pc_write_en),
        .if_id_write_en (if_id_write_en),
        .if_id_clean    (if_id_clean),
        .doJump         (doJump),
        .jump_target    (jump_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_id_instr    (if_id_instr),
        .if_id_pc1      (if_id_pc1),
        .if_id_valid    (if_id_valid),
        .bubble_count   (bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: an outstanding-fetch record, a stale flag, a skid queue and
    // the IF/ID contents, advanced once per clock from the stage's rules.
    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc1;
    } fetched_t;

    logic [15:0] m_pc, m_addr, m_instr, m_pc1, m_bcnt;
    logic        m_req, m_kill, m_valid;
    fetched_t    m_skid[$];
    logic        rand_data = 1'b0;

    task automatic model_reset();
        m_pc = 16'h0; m_addr = 16'h0; m_req = 1'b0; m_kill = 1'b0;
        m_skid.delete();
        m_instr = 16'h0; m_pc1 = 16'h0; m_valid = 1'b0; m_bcnt = 16'h0;
    endtask

    task automatic model_step(input logic pcwe, input logic ifwe, input logic clean,
                              input logic jmp, input logic [15:0] tgt,
                              input logic ack, input logic [15:0] rd);
        logic        adv, have;
        fetched_t    f;
        adv  = pcwe & ifwe;
        have = 1'b0;
        f    = '{16'h0, 16'h0};
        if (m_skid.size() != 0) begin
            if (jmp) begin
                m_skid.delete();
                m_pc = tgt;
            end else if (adv) begin
                f = m_skid.pop_front();
                have = 1'b1;
                m_pc = m_pc + 16'd1;
            end
        end else if (!m_req) begin
            m_req  = 1'b1;
            m_addr = jmp ? tgt : m_pc;
            if (jmp) m_pc = tgt;
        end else if (ack) begin
            m_req = 1'b0;
            if (m_kill || jmp) begin
                m_kill = 1'b0;
                if (jmp) m_pc = tgt;
            end else if (adv) begin
                f = '{rd, m_addr + 16'd1};
                have = 1'b1;
                m_pc = m_pc + 16'd1;
                m_addr = m_pc;
                m_req = 1'b1;
            end else begin
                m_skid.push_back('{rd, m_addr + 16'd1});
            end
        end else if (jmp) begin
            m_kill = 1'b1;
            m_pc = tgt;
        end

        if (clean) begin
            m_instr = 16'h0; m_pc1 = 16'h0; m_valid = 1'b0;
        end else if (ifwe) begin
            if (have) begin
                m_instr = f.instr; m_pc1 = f.pc1; m_valid = 1'b1;
            end else begin
                m_instr = 16'h0; m_pc1 = 16'h0; m_valid = 1'b0;
                if (m_bcnt != 16'hFFFF) m_bcnt = m_bcnt + 16'd1;
            end
        end
    endtask

    task automatic check_outputs();
        check("imem_req", 16'(imem_req), 16'(m_req));
        if (m_req) check("imem_addr", imem_addr, m_addr);
        check("if_id_instr", if_id_instr, m_instr);
        check("if_id_pc1", if_id_pc1, m_pc1);
        check("if_id_valid", 16'(if_id_valid), 16'(m_valid));
        check("bubble_count", bubble_count, m_bcnt);
    endtask

    // Called at a falling edge: check, drive one cycle of inputs, step the model.
    task automatic drive_cycle(input logic pcwe, input logic ifwe, input logic clean,
                               input logic jmp, input logic [15:0] tgt, input logic ack_req);
        logic [15:0] rd;
        logic        ack;
        check_outputs();
        ack = ack_req & m_req;
        rd  = rand_data ? 16'($urandom) : (m_addr ^ 16'hA5A5);
        pc_write_en    = pcwe;
        if_id_write_en = ifwe;
        if_id_clean    = clean;
        doJump         = jmp;
        jump_target    = tgt;
        imem_ack       = ack;
        imem_rdata     = rd;
        model_step(pcwe, ifwe, clean, jmp, tgt, ack, rd);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        pc_write_en = 1'b0; if_id_write_en = 1'b0; if_id_clean = 1'b0;
        doJump = 1'b0; jump_target = 16'h0; imem_ack = 1'b0; imem_rdata = 16'h0;
    endtask

    // Asserts reset mid-cycle and checks the outputs clear without waiting for a clock edge.
    task automatic do_reset();
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        check("rst_req", 16'(imem_req), 16'h0);
        check("rst_instr", if_id_instr, 16'h0);
        check("rst_pc1", if_id_pc1, 16'h0);
        check("rst_valid", 16'(if_id_valid), 16'h0);
        check("rst_bcnt", bubble_count, 16'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [15:0] b0;

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        check("init_req", 16'(imem_req), 16'h0);
        check("init_valid", 16'(if_id_valid), 16'h0);
        check("init_bcnt", bubble_count, 16'h0);
        rst = 1'b0;

        // First fill with ack every cycle; first cycle holds IF/ID so no bubble is counted.
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        check("issue_req", 16'(imem_req), 16'h1);
        check("issue_addr", imem_addr, 16'h0000);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        check("fill_instr", if_id_instr, 16'hA5A5);
        check("fill_pc1", if_id_pc1, 16'h0001);
        check("fill_valid", 16'(if_id_valid), 16'h1);
        check("b2b_addr", imem_addr, 16'h0001);
        repeat (4) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        check("b2b_bcnt", bubble_count, 16'h0);
        check("b2b_addr5", imem_addr, 16'h0005);
        check("b2b_instr4", if_id_instr, 16'hA5A1);

        // Ack at addr 5 under a 4-cycle stall lands in the skid buffer.
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        check("hold_req", 16'(imem_req), 16'h0);
        check("hold_instr", if_id_instr, 16'hA5A1);
        check("hold_pc1", if_id_pc1, 16'h0005);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        check("drain_instr", if_id_instr, 16'hA5A0);
        check("drain_pc1", if_id_pc1, 16'h0006);
        check("drain_valid", 16'(if_id_valid), 16'h1);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        check("drain_next_addr", imem_addr, 16'h0006);

        // Latency-3 fetch of addr 6: two bubbles.
        b0 = m_bcnt;
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        check("lat3_bcnt", bubble_count, b0 + 16'd2);
        check("lat3_instr", if_id_instr, 16'hA5A3);
        check("lat3_addr", imem_addr, 16'h0007);

        // Jump two cycles before the ack of addr 7: that data is discarded.
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 1'b0);
        check("kill_addr_held", imem_addr, 16'h0007);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        check("kill_valid", 16'(if_id_valid), 16'h0);
        check("kill_req", 16'(imem_req), 16'h0);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        check("jump_addr", imem_addr, 16'h0040);

        // Jump and ack together, with flush.
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1);
        check("jack_instr", if_id_instr, 16'h0000);
        check("jack_valid", 16'(if_id_valid), 16'h0);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        check("jack_addr", imem_addr, 16'h1234);

        // PC wrap at 16'hFFFF.
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        check("wrap_addr", imem_addr, 16'hFFFF);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        check("wrap_pc1", if_id_pc1, 16'h0000);
        check("wrap_instr", if_id_instr, 16'h5A5A);
        check("wrap_next_addr", imem_addr, 16'h0000);
        check("wrap_req", 16'(imem_req), 16'h1);

        // Reset with a fetch outstanding.
        do_reset();

        // Randomized traffic against the model.
        rand_data = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic pcwe, ifwe;
            logic [15:0] tgt;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                r = $urandom_range(0, 9);
                pcwe = (r <= 6) || (r == 8);
                ifwe = (r <= 6) || (r == 9);
                tgt  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                drive_cycle(pcwe, ifwe, ($urandom_range(0, 9) == 0),
                            ($urandom_range(0, 11) == 0), tgt,
                            ($urandom_range(0, 2) == 0));
            end
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
